// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode control sequencer: state, IR, status and control-word unpacking
//
// Purpose: steps FETCH -> EX0..EX2 under control of a 33-bit control word. In
// FETCH a fixed fetch word drives the datapath. In the execute states the
// decoders supply the word via cw_decoded.
// Optional feature: define CTRL_SEQ_INSTR_COUNT_EN to build the retired-instruction
// counter. Without it, instr_count is tied to zero and no counter register exists.
//
// Ports:
//   clock        rising-edge system clock
//   reset        synchronous active-low reset (takes priority over stall)
//   instr_in     instruction word from RAM, captured into ir in FETCH
//   cw_decoded   control word from the decoders, active in EX0/EX1/EX2
//   status_in    ALU status flags, captured when status_ld is set
//   stall        freezes sequencing and masks side-effecting fields
//   state        current sequencer state (to decoders)
//   ir           instruction register (to decoders)
//   status       registered status flags (to decoders)
//   alu_en .. status_ld  unpacked control fields of the active word
//   instr_count  retired-instruction count (zero when the counter is not built)

module control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [32:0] cw_decoded,
  input  logic [4:0]  status_in,
  input  logic        stall,
  output logic [1:0]  state,
  output logic [31:0] ir,
  output logic [4:0]  status,
  output logic        alu_en,
  output logic        alu_bs,
  output logic [4:0]  alu_fs,
  output logic        rf_b_en,
  output logic [4:0]  rf_sa,
  output logic [4:0]  rf_sb,
  output logic [4:0]  rf_da,
  output logic        rf_w,
  output logic        ram_en,
  output logic        ram_w,
  output logic        pc_en,
  output logic [1:0]  pc_fs,
  output logic        pc_is,
  output logic        status_ld,
  output logic [31:0] instr_count
);

  localparam logic [1:0] ST_FETCH = 2'b00;

  // Fetch word: read RAM at PC, increment PC, no register or status writes,
  // then go to EX0. Because next_state is fixed at 01, FETCH can never loop on itself.
  localparam logic [32:0] FETCH_WORD = {
    1'b0,       // alu_en
    1'b1,       // alu_bs
    5'b11111,   // alu_fs
    1'b0,       // rf_b_en
    5'd31,      // rf_sa
    5'd31,      // rf_sb
    5'd31,      // rf_da
    1'b0,       // rf_w
    1'b1,       // ram_en
    1'b0,       // ram_w
    1'b0,       // pc_en
    2'b01,      // pc_fs
    1'b0,       // pc_is
    1'b0,       // status_ld
    2'b01       // next_state
  };

  logic [1:0]  state_q,  state_d;
  logic [31:0] ir_q,     ir_d;
  logic [4:0]  status_q, status_d;

  logic [32:0] active_w;
  logic        suppress;
  logic        in_fetch;

  assign in_fetch = (state_q == ST_FETCH);
  assign active_w = in_fetch ? FETCH_WORD : cw_decoded;

  // Side-effecting fields are masked during stall and during reset.
  // This stops a frozen or abandoned instruction from writing anything.
  assign suppress = stall | ~reset;

  always_comb begin
    alu_en    = active_w[32];
    alu_bs    = active_w[31];
    alu_fs    = active_w[30:26];
    rf_b_en   = active_w[25];
    rf_sa     = active_w[24:20];
    rf_sb     = active_w[19:15];
    rf_da     = active_w[14:10];
    rf_w      = active_w[9] & ~suppress;
    ram_en    = active_w[8];
    ram_w     = active_w[7] & ~suppress;
    pc_en     = active_w[6];
    pc_fs     = suppress ? 2'b00 : active_w[5:4];
    pc_is     = active_w[3];
    status_ld = active_w[2] & ~suppress;
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    status_d = status_q;
    if (!stall) begin
      state_d = active_w[1:0];
      if (in_fetch) begin
        ir_d = instr_in;
      end
      if (active_w[2]) begin
        status_d = status_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      ir_q     <= 32'd0;
      status_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      status_q <= status_d;
    end
  end

  assign state  = state_q;
  assign ir     = ir_q;
  assign status = status_q;

`ifdef CTRL_SEQ_INSTR_COUNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire;

  // An instruction retires when an execute state hands control back to FETCH.
  assign retire = ~stall & ~in_fetch & (active_w[1:0] == ST_FETCH);

  always_comb begin
    instr_count_d = instr_count_q;
    if (retire) begin
      instr_count_d = instr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_count_q <= 32'd0;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule
